obj_cmd_arbiter: RTL
====================

Name: obj_cmd_arbiter

Overview:
Two-port command arbiter and sequencer in front of the object allocation unit. Port A serves the matrix unit and port B serves the host command path. The block accepts object commands (create, delete, delete-all, reference) and serializes them round-robin. It drives the object unit's single-cycle command pulses, waits for the unit's completion handshake and returns the resulting object number, base address and status to the requester. It guarantees one outstanding command at a time and never issues a create while object memory is full.

Parameters:
TIMEOUT, 48, maximum WAIT cycles for addr_vld before the command is failed (covers the worst-case 31-entry free-slot search plus margin).
TO_W, 6, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
req_a  in  1  port A request; held until ack_a
op_a  in  2  port A opcode: 00 create, 01 delete, 10 delete-all, 11 reference
num_a  in  5  port A object number (delete/reference only)
ack_a  out  1  one-cycle pulse: port A command accepted
resp_vld_a  out  1  one-cycle pulse: response for port A on the shared response bus
req_b, op_b, num_b, ack_b, resp_vld_b  same as port A, for port B
resp_err  out  2  00 ok, 01 full (create refused), 10 timeout
resp_obj  out  5  object number (create: allocated slot; others: num echoed)
resp_addr  out  9  object base address from object unit (create/reference); 0 otherwise
busy  out  1  high whenever state != IDLE
crt_obj, del_obj, del_all, ref_addr  out  1  command pulses to object unit
obj_num  out  5  object number to object unit, valid with pulse
addr  in  9  from object unit
addr_vld  in  1  from object unit
lst_stored_obj  in  5  from object unit
lst_stored_obj_vld  in  1  from object unit
obj_mem_full  in  1  from object unit

Behaviour:
- All outputs are registered. On reset (rst sampled high at posedge): state=IDLE, all pulses/acks/resp_vld=0, resp_err=00, resp_obj=0, resp_addr=0, obj_num=0, last_gnt=B (so A wins the first tie), timeout counter=0. Reset mid-operation drops the in-flight command without a response; requesters must reissue.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE, cycle T, some req high: grant per round-robin. The single requester wins. On a tie, the port not equal to last_gnt wins. Latch op/num/port and update last_gnt.
  - Create with obj_mem_full=1 at T: no pulse. At T+1 raise ack_x=1 and go to RESP with err=01.
  - Otherwise at T+1: ack_x=1, exactly one command pulse=1, obj_num=latched num (0 for create/delete-all). State goes to ISSUE.
- ISSUE (T+1): pulses drop next cycle. Create/reference go to WAIT with counter cleared. Delete/delete-all go to RESP with err=00, resp_addr=0.
- WAIT: on lst_stored_obj_vld, capture lst_stored_obj into resp_obj. On addr_vld, capture addr into resp_addr and go to RESP with err=00. For reference, resp_obj=latched num. Otherwise increment the counter; when counter==TIMEOUT-1 with no addr_vld, go to RESP with err=10. addr_vld and counter expiry in the same cycle: addr_vld wins.
- RESP: resp_vld of the owning port=1 for exactly one cycle, with resp_err/obj/addr valid. Next state is IDLE. resp_* buses hold their values until the next RESP.
- IDLE may grant in the cycle after RESP. Minimum request-to-request spacing: 3 cycles for delete, 4+search for create.
- req/op/num are sampled only in IDLE; changes while busy are ignored. A requester must not drop req before ack.
- addr_vld/lst_stored_obj_vld arriving outside WAIT are ignored.
- Exactly one of crt_obj/del_obj/del_all/ref_addr is high in any cycle, and only in ISSUE.

Test Plan:
1. Reset, req_a=1 op=00. Object-unit model returns lst_stored_obj_vld=1 with 0 at T+2 and addr_vld=1 with addr=0 at T+3. Required: ack_a at T+1, crt_obj at T+1 only, resp_vld_a at T+4, resp_obj=0, resp_addr=0, resp_err=00.
2. req_a and req_b both create at T (post-reset). Required: A served first. B acked only after A's RESP; B gets resp_obj=1, addr=18. A third A/B tie then goes to A (B was last).
3. obj_mem_full=1, req_b create. Required: ack_b at T+1, no crt_obj ever, resp_vld_b at T+2, resp_err=01.
4. req_a delete num=5. Required: del_obj=1 and obj_num=5 at T+1, resp_vld_a at T+2, resp_obj=5, resp_addr=0, err=00.
5. TIMEOUT=8, reference num=3, model never asserts addr_vld. Required: ref_addr at T+1, resp_vld with err=10 at T+10, busy high T+1..T+10.
6. rst asserted during WAIT. Required: next cycle all outputs 0, no resp_vld. A new create afterwards completes normally.

Source files
------------

// File: rtl/obj_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// obj_cmd_arbiter
//
// Two-port round-robin command arbiter / sequencer sitting in front of the
// object allocation unit. Port A belongs to the matrix unit, port B to the
// host command path. One command is outstanding at a time. The block turns a
// granted request into a single-cycle command pulse, waits for the unit's
// completion (create/reference), and returns status, object number and base
// address on a shared response bus.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_x / op_x / num_x     request, opcode (00 crt, 01 del, 10 del-all,
//                            11 ref) and object number, per port x = a, b
//   ack_x                    one-cycle accept pulse
//   resp_vld_x               one-cycle response-valid pulse
//   resp_err/obj/addr        shared response bus (00 ok, 01 full, 10 timeout)
//   busy                     high whenever the sequencer is not IDLE
//   crt_obj/del_obj/del_all/ref_addr, obj_num   command to object unit
//   addr, addr_vld, lst_stored_obj(_vld), obj_mem_full   from object unit
// ---------------------------------------------------------------------------
module obj_cmd_arbiter #(
    parameter int TIMEOUT = 48,
    parameter int TO_W    = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic [1:0] op_a,
    input  logic [4:0] num_a,
    output logic       ack_a,
    output logic       resp_vld_a,
    input  logic       req_b,
    input  logic [1:0] op_b,
    input  logic [4:0] num_b,
    output logic       ack_b,
    output logic       resp_vld_b,
    output logic [1:0] resp_err,
    output logic [4:0] resp_obj,
    output logic [8:0] resp_addr,
    output logic       busy,
    output logic       crt_obj,
    output logic       del_obj,
    output logic       del_all,
    output logic       ref_addr,
    output logic [4:0] obj_num,
    input  logic [8:0] addr,
    input  logic       addr_vld,
    input  logic [4:0] lst_stored_obj,
    input  logic       lst_stored_obj_vld,
    input  logic       obj_mem_full
);

    localparam logic [1:0] OP_CRT = 2'b00;
    localparam logic [1:0] OP_DEL = 2'b01;
    localparam logic [1:0] OP_REF = 2'b11;

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_FULL = 2'b01;
    localparam logic [1:0] ERR_TO   = 2'b10;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state_reg;
    logic            last_gnt_reg;   // 0 = A, 1 = B
    logic            port_reg;       // owner of the in-flight command
    logic [1:0]      op_reg;
    logic [4:0]      num_reg;
    logic            full_reg;       // create refused at grant time
    logic [4:0]      slot_reg;       // object number to report from WAIT
    logic [TO_W-1:0] cnt_reg;
    logic [1:0]      ack_reg;        // {B, A}
    logic [1:0]      resp_vld_reg;   // {B, A}
    logic [3:0]      pulse_reg;      // one-hot by opcode: {ref, del_all, del, crt}

    // Grant selection: a lone requester wins; on a tie the port that was
    // not granted last time wins.
    logic       gnt_b;
    logic [1:0] sel_op;
    logic [4:0] sel_num;
    logic [4:0] wait_obj;

    always_comb begin
        gnt_b = req_b;
        if (req_a && req_b) begin
            gnt_b = ~last_gnt_reg;
        end
        sel_op  = gnt_b ? op_b  : op_a;
        sel_num = gnt_b ? num_b : num_a;
        // A slot reported in the same cycle as addr_vld is still honoured.
        wait_obj = (op_reg == OP_CRT && lst_stored_obj_vld) ? lst_stored_obj : slot_reg;
    end

    assign {ack_b, ack_a}                     = ack_reg;
    assign {resp_vld_b, resp_vld_a}           = resp_vld_reg;
    assign {ref_addr, del_all, del_obj, crt_obj} = pulse_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            last_gnt_reg <= 1'b1;
            port_reg     <= 1'b0;
            op_reg       <= OP_CRT;
            num_reg      <= '0;
            full_reg     <= 1'b0;
            slot_reg     <= '0;
            cnt_reg      <= '0;
            ack_reg      <= '0;
            resp_vld_reg <= '0;
            pulse_reg    <= '0;
            resp_err     <= ERR_OK;
            resp_obj     <= '0;
            resp_addr    <= '0;
            busy         <= 1'b0;
            obj_num      <= '0;
        end else begin
            // Pulses default low every cycle.
            ack_reg      <= '0;
            resp_vld_reg <= '0;
            pulse_reg    <= '0;

            case (state_reg)
                IDLE: begin
                    if (req_a || req_b) begin
                        port_reg     <= gnt_b;
                        last_gnt_reg <= gnt_b;
                        op_reg       <= sel_op;
                        num_reg      <= sel_num;
                        ack_reg      <= gnt_b ? 2'b10 : 2'b01;
                        state_reg    <= ISSUE;
                        busy         <= 1'b1;
                        if (sel_op == OP_CRT && obj_mem_full) begin
                            // Never issue a create into a full memory.
                            full_reg <= 1'b1;
                        end else begin
                            full_reg  <= 1'b0;
                            pulse_reg <= 4'b0001 << sel_op;
                            obj_num   <= (sel_op == OP_DEL || sel_op == OP_REF) ? sel_num : 5'd0;
                        end
                    end
                end

                ISSUE: begin
                    if (full_reg) begin
                        state_reg    <= RESP;
                        resp_vld_reg <= port_reg ? 2'b10 : 2'b01;
                        resp_err     <= ERR_FULL;
                        resp_obj     <= '0;
                        resp_addr    <= '0;
                    end else if (op_reg == OP_CRT || op_reg == OP_REF) begin
                        state_reg <= WAIT;
                        cnt_reg   <= '0;
                        slot_reg  <= (op_reg == OP_REF) ? num_reg : 5'd0;
                    end else begin
                        state_reg    <= RESP;
                        resp_vld_reg <= port_reg ? 2'b10 : 2'b01;
                        resp_err     <= ERR_OK;
                        resp_obj     <= num_reg;
                        resp_addr    <= '0;
                    end
                end

                WAIT: begin
                    if (op_reg == OP_CRT && lst_stored_obj_vld) begin
                        slot_reg <= lst_stored_obj;
                    end
                    if (addr_vld) begin
                        state_reg    <= RESP;
                        resp_vld_reg <= port_reg ? 2'b10 : 2'b01;
                        resp_err     <= ERR_OK;
                        resp_obj     <= wait_obj;
                        resp_addr    <= addr;
                    end else if (cnt_reg == TO_W'(TIMEOUT - 1)) begin
                        state_reg    <= RESP;
                        resp_vld_reg <= port_reg ? 2'b10 : 2'b01;
                        resp_err     <= ERR_TO;
                        resp_obj     <= wait_obj;
                        resp_addr    <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + TO_W'(1);
                    end
                end

                RESP: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end

                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
